// File: rtl/tm_twiddle_rotator.sv
// tm_twiddle_rotator: streaming 64-point twiddle rotation, 3-stage pipeline, nine first-octant constant multipliers.
// Define TM_TWIDDLE_SAT_EN to clamp outputs on overflow; otherwise results wrap two's-complement.

module tm_twiddle_const_mult #(
    parameter int K = 0,
    parameter int DATA_WIDTH = 14
) (
    input  logic signed [DATA_WIDTH-1:0] re,
    input  logic signed [DATA_WIDTH-1:0] im,
    output logic signed [DATA_WIDTH-1:0] rere,
    output logic signed [DATA_WIDTH-1:0] imim,
    output logic signed [DATA_WIDTH-1:0] reim,
    output logic signed [DATA_WIDTH-1:0] imre
);
    localparam int PW = DATA_WIDTH + 15;

    // cos(2*pi*k/64) in Q13 for k = 0..16, so sin(k) = cos(16 - k)
    function automatic int cos_q13(input int k);
        case (k)
            0:  return 8192;
            1:  return 8153;
            2:  return 8035;
            3:  return 7839;
            4:  return 7568;
            5:  return 7225;
            6:  return 6811;
            7:  return 6333;
            8:  return 5793;
            9:  return 5197;
            10: return 4551;
            11: return 3862;
            12: return 3135;
            13: return 2378;
            14: return 1598;
            15: return 803;
            default: return 0;
        endcase
    endfunction

    localparam logic signed [14:0] C = 15'(cos_q13(K));
    localparam logic signed [14:0] S = 15'(cos_q13(16 - K));

    logic signed [PW-1:0] p_rere, p_imim, p_reim, p_imre;

    always_comb begin
        p_rere = PW'(re) * PW'(C);
        p_imim = PW'(im) * PW'(S);
        p_reim = PW'(re) * PW'(S);
        p_imre = PW'(im) * PW'(C);
        rere = DATA_WIDTH'(p_rere >>> 13);
        imim = DATA_WIDTH'(p_imim >>> 13);
        reim = DATA_WIDTH'(p_reim >>> 13);
        imre = DATA_WIDTH'(p_imre >>> 13);
    end
endmodule

module tm_twiddle_rotator #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic [DATA_WIDTH-1:0] din_real,
    input  logic [DATA_WIDTH-1:0] din_imag,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic [DATA_WIDTH-1:0] dout_real,
    output logic [DATA_WIDTH-1:0] dout_imag
);
    localparam int W = DATA_WIDTH;

    logic [5:0] n_q, n_d, n_use, e;
    logic v1_q, v1_d, sop1_q, sop1_d, v2_q, v2_d, sop2_q, sop2_d, v3_q, v3_d, sop3_q, sop3_d;
    logic [3:0] k1_q, k1_d;
    logic [2:0] q1_q, q1_d, q2_q, q2_d;
    logic signed [W-1:0] re1_q, re1_d, im1_q, im1_d;
    logic signed [W-1:0] rere2_q, rere2_d, imim2_q, imim2_d, reim2_q, reim2_d, imre2_q, imre2_d;
    logic signed [W-1:0] dre3_q, dre3_d, dim3_q, dim3_d;
    logic signed [W-1:0] rere_w [9], imim_w [9], reim_w [9], imre_w [9];
    logic swap, negc, negs;
    logic signed [W:0] ca, cb, da, db, ta, tb, td, te, sum_re, sum_im;

    function automatic logic signed [W-1:0] narrow(input logic signed [W:0] x);
`ifdef TM_TWIDDLE_SAT_EN
        return (x[W] != x[W-1]) ? (x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : x[W-1:0];
`else
        return W'(x);
`endif
    endfunction

    for (genvar g = 0; g < 9; g++) begin : twiddle64
        tm_twiddle_const_mult #(.K(g), .DATA_WIDTH(W)) u_mult (
            .re(re1_q), .im(im1_q),
            .rere(rere_w[g]), .imim(imim_w[g]), .reim(reim_w[g]), .imre(imre_w[g])
        );
    end

    always_comb begin
        n_use = in_sop ? 6'd0 : n_q;
        n_d = in_valid ? n_use + 6'd1 : n_q;
        e = 6'(n_use[5:4]) * 6'(n_use[3:0]);
        k1_d = e[3] ? 4'd8 - {1'b0, e[2:0]} : {1'b0, e[2:0]};
        q1_d = e[5:3];
        v1_d = in_valid;
        sop1_d = in_valid & in_sop;
        re1_d = din_real;
        im1_d = din_imag;
        rere2_d = rere_w[k1_q];
        imim2_d = imim_w[k1_q];
        reim2_d = reim_w[k1_q];
        imre2_d = imre_w[k1_q];
        q2_d = q1_q;
        v2_d = v1_q;
        sop2_d = sop1_q;
        // octants 1,2,5,6 swap cos/sin roles; C is negative in 2..5, S in 4..7
        swap = q2_q[0] ^ q2_q[1];
        negc = q2_q[2] ^ q2_q[1];
        negs = q2_q[2];
        ca = (W+1)'(swap ? reim2_q : rere2_q);
        cb = (W+1)'(swap ? imre2_q : imim2_q);
        da = (W+1)'(swap ? imim2_q : imre2_q);
        db = (W+1)'(swap ? rere2_q : reim2_q);
        ta = negc ? -ca : ca;
        tb = negs ? -cb : cb;
        td = negc ? -da : da;
        te = negs ? -db : db;
        sum_re = ta + tb;
        sum_im = td - te;
        dre3_d = narrow(sum_re);
        dim3_d = narrow(sum_im);
        v3_d = v2_q;
        sop3_d = sop2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= '0;
            v1_q <= 1'b0;
            sop1_q <= 1'b0;
            k1_q <= '0;
            q1_q <= '0;
            re1_q <= '0;
            im1_q <= '0;
            rere2_q <= '0;
            imim2_q <= '0;
            reim2_q <= '0;
            imre2_q <= '0;
            q2_q <= '0;
            v2_q <= 1'b0;
            sop2_q <= 1'b0;
            dre3_q <= '0;
            dim3_q <= '0;
            v3_q <= 1'b0;
            sop3_q <= 1'b0;
        end else begin
            n_q <= n_d;
            v1_q <= v1_d;
            sop1_q <= sop1_d;
            k1_q <= k1_d;
            q1_q <= q1_d;
            re1_q <= re1_d;
            im1_q <= im1_d;
            rere2_q <= rere2_d;
            imim2_q <= imim2_d;
            reim2_q <= reim2_d;
            imre2_q <= imre2_d;
            q2_q <= q2_d;
            v2_q <= v2_d;
            sop2_q <= sop2_d;
            dre3_q <= dre3_d;
            dim3_q <= dim3_d;
            v3_q <= v3_d;
            sop3_q <= sop3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_sop = sop3_q;
    assign dout_real = dre3_q;
    assign dout_imag = dim3_q;
endmodule

// File: tb/tb_tm_twiddle_rotator.sv
// tb_tm_twiddle_rotator: directed vector table, corner sequences and random stimulus against a floating-point rotation model.
// Honours TM_TWIDDLE_SAT_EN the same way as the design.

module tb_tm_twiddle_rotator;
    logic clk = 1'b0;
    logic rst, in_valid, in_sop, out_valid, out_sop;
    logic [13:0] din_real, din_imag, dout_real, dout_imag;

    always #5 clk = ~clk;

    tm_twiddle_rotator #(.DATA_WIDTH(14)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
        .din_real(din_real), .din_imag(din_imag),
        .out_valid(out_valid), .out_sop(out_sop),
        .dout_real(dout_real), .dout_imag(dout_imag)
    );

    typedef struct {bit v; bit sop; int re; int im; int tol; int id;} exp_t;
    typedef struct {int n; int re; int im; int xr; int xi; int tol;} vec_t;

    exp_t pipe [3];
    vec_t vecs [8];
    int n_ref = 0;
    int checks = 0;
    int passed = 0;

    function automatic int narrow(input real x);
        int r;
        r = $rtoi(x < 0.0 ? x - 0.5 : x + 0.5);
`ifdef TM_TWIDDLE_SAT_EN
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
`else
        r = r & 16383;
        if (r >= 8192) r -= 16384;
`endif
        return r;
    endfunction

    // ideal rotation by W64^e, e = (n div 16) * (n mod 16)
    function automatic exp_t model(input bit sop, input int re, input int im, input int n);
        exp_t m;
        int e;
        real th;
        e = (n / 16) * (n % 16);
        th = 2.0 * 3.14159265358979 * e / 64.0;
        m.v = 1'b1;
        m.sop = sop;
        m.re = narrow(re * $cos(th) + im * $sin(th));
        m.im = narrow(im * $cos(th) - re * $sin(th));
        m.tol = 3;
        m.id = -1;
        return m;
    endfunction

    task automatic chk(input int id, input string what, input int act, input int exp, input int tol);
        int d;
        d = (act - exp) & 16383;
        if (d >= 8192) d -= 16384;
        checks++;
        if (d <= tol && d >= -tol) passed++;
        else $display("FAIL vec%0d %s: got %0d want %0d (tol %0d)", id, what, act, exp, tol);
    endtask

    task automatic chk_zero(input int id);
        chk(id, "out_valid", int'(out_valid), 0, 0);
        chk(id, "out_sop", int'(out_sop), 0, 0);
        chk(id, "dout_real", int'($signed(dout_real)), 0, 0);
        chk(id, "dout_imag", int'($signed(dout_imag)), 0, 0);
    endtask

    task automatic step(input bit v, input bit sop, input int re, input int im,
                        input int vid, input int xr, input int xi, input int tol);
        exp_t e;
        int use_n;
        e = '{default: 0};
        e.id = -1;
        in_valid = v;
        in_sop = sop;
        din_real = 14'(re);
        din_imag = 14'(im);
        if (v) begin
            use_n = sop ? 0 : n_ref;
            n_ref = (use_n + 1) % 64;
            e = model(sop, re, im, use_n);
            if (vid >= 0) begin
                e.re = xr;
                e.im = xi;
                e.tol = tol;
                e.id = vid;
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        @(posedge clk);
        #1;
        chk(pipe[2].id, "out_valid", int'(out_valid), int'(pipe[2].v), 0);
        if (pipe[2].v) begin
            chk(pipe[2].id, "out_sop", int'(out_sop), int'(pipe[2].sop), 0);
            chk(pipe[2].id, "dout_real", int'($signed(dout_real)), pipe[2].re, pipe[2].tol);
            chk(pipe[2].id, "dout_imag", int'($signed(dout_imag)), pipe[2].im, pipe[2].tol);
        end
    endtask

    task automatic zeros(input int cnt);
        repeat (cnt) step(1'b1, 1'b0, 0, 0, -1, 0, 0, 0);
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) step(1'b0, 1'b0, 0, 0, -1, 0, 0, 0);
    endtask

    function automatic int rnd14();
        return int'($urandom_range(16383)) - 8192;
    endfunction

    initial begin
        vecs[0] = '{0, 1000, 0, 1000, 0, 0};
        vecs[1] = '{5, -1234, 567, -1234, 567, 0};
        vecs[2] = '{40, 1000, 0, 0, -1000, 0};
        vecs[3] = '{20, 1000, 0, 924, -383, 2};
        vecs[4] = '{24, 1000, 0, 707, -707, 2};
        vecs[5] = '{57, 0, 1000, 471, -882, 2};
`ifdef TM_TWIDDLE_SAT_EN
        vecs[6] = '{24, -8192, -8192, -8192, 0, 2};
`else
        vecs[6] = '{24, -8192, -8192, 4798, 0, 2};
`endif
        vecs[7] = '{36, 0, 1000, 707, 707, 2};
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        din_real = '0;
        din_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(-2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].n == 0) step(1'b1, 1'b1, vecs[i].re, vecs[i].im, i, vecs[i].xr, vecs[i].xi, vecs[i].tol);
            else begin
                step(1'b1, 1'b1, 0, 0, -1, 0, 0, 0);
                zeros(vecs[i].n - 1);
                step(1'b1, 1'b0, vecs[i].re, vecs[i].im, i, vecs[i].xr, vecs[i].xi, vecs[i].tol);
            end
        end
        // bubbles: counter must hold across 5 idle cycles
        step(1'b1, 1'b1, 0, 0, -1, 0, 0, 0);
        zeros(19);
        idle(5);
        zeros(20);
        step(1'b1, 1'b0, 1000, 0, 100, 0, -1000, 0);
        // wrap: sample after n=63 without sop is n=0
        step(1'b1, 1'b1, 0, 0, -1, 0, 0, 0);
        zeros(63);
        step(1'b1, 1'b0, 1000, 0, 101, 1000, 0, 0);
        step(1'b1, 1'b0, 0, 1000, 102, 0, 1000, 0);
        // reset mid-frame with samples in flight
        step(1'b1, 1'b1, rnd14(), rnd14(), -1, 0, 0, 0);
        repeat (30) step(1'b1, 1'b0, rnd14(), rnd14(), -1, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_zero(103);
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        n_ref = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        step(1'b1, 1'b0, 1000, 0, 104, 1000, 0, 0);
        // random traffic with occasional restarts and bubbles
        repeat (800) step($urandom_range(3) != 0, $urandom_range(39) == 0, rnd14(), rnd14(), -1, 0, 0, 0);
        idle(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
